sd_blk_arbiter: RTL
===================

Name: sd_blk_arbiter

Overview:
- Sits directly downstream of the CoCo SDC/FDC top.
- Merges up to four MiSTer SD block-level request channels onto the single hps_io SD channel. The four channels are SDC/FDC drives 0-1 plus two further clients, such as the 4-drive FDC in another MPI slot.
- Grants one channel at a time using round-robin priority and latches that channel's LBA and operation.
- Routes host_ack, the byte-level buffer write strobe and the buffer read-back data between the granted client and the host.
- Provides an abort path and an ack-timeout recovery path.

Parameters:
NUM_CH, 4, number of client channels (2..4); inputs above NUM_CH-1 are ignored.
TIMEOUT_CYC, 24'd10000000, CLK cycles allowed in ISSUE before the request is abandoned; 0 disables the timeout.

Ports:
CLK  in  1  system clock, all logic on rising edge
RESET_N  in  1  asynchronous active-low reset
cl_lba  in  32 x4  per-client block LBA (unpacked [4])
cl_rd  in  4  per-client read request, level, held until ack
cl_wr  in  4  per-client write request, level, held until ack
cl_ack  out  4  per-client ack (host_ack routed to the granted client only)
cl_buff_din  in  8 x4  per-client buffer read-back data for host writes
cl_buff_wr  out  4  per-client buffer write strobe (host sd_buff_wr gated to the grant)
host_lba  out  32  LBA to hps_io
host_rd  out  1  read request to hps_io
host_wr  out  1  write request to hps_io
host_ack  in  1  ack from hps_io
host_buff_wr  in  1  byte strobe from hps_io
host_buff_din  out  8  byte to hps_io = cl_buff_din[grant], combinational
busy  out  1  high in any state other than IDLE
grant  out  2  index of the current or last granted channel
timeout_err  out  1  sticky; set on timeout, cleared by reset only

Behaviour:
- Reset (async, RESET_N low) forces the following immediately, including mid-transfer:
  - state=IDLE, grant=0, last=NUM_CH-1.
  - host_lba=0, host_rd=0, host_wr=0.
  - cl_ack=0, cl_buff_wr=0, busy=0, timeout_err=0.
- A channel requests when req[i] = cl_rd[i] | cl_wr[i] is high and i < NUM_CH.
- States: IDLE, ISSUE, ACTIVE, DONE.
- IDLE:
  - Scan channels last+1, last+2, ... mod NUM_CH; the first requesting channel wins.
  - On the edge where a winner is found:
    - grant<=i, host_lba<=cl_lba[i].
    - Operation: host_rd<=cl_rd[i], host_wr<=cl_wr[i]&~cl_rd[i] (read wins if both are set).
    - Timer cleared; go to ISSUE.
  - Latency: request visible at edge N gives host_rd/host_wr high after edge N.
- ISSUE:
  - host_rd/host_wr held and the timer increments.
  - If host_ack=1: deassert host_rd/host_wr; go to ACTIVE.
  - Else if req[grant]=0 (client aborted before ack): deassert host_rd/host_wr; go to IDLE; last is unchanged.
  - Else if TIMEOUT_CYC!=0 and timer==TIMEOUT_CYC-1: deassert host_rd/host_wr; timeout_err<=1; last<=grant; go to IDLE.
  - The ack check has priority over the abort check, and the abort check has priority over the timeout check.
- ACTIVE: stays until host_ack=0, then goes to DONE. Client request drop during ACTIVE is normal and does not affect the state.
- DONE: one cycle; last<=grant; go to IDLE. Consequence: back-to-back transfers have at least one idle cycle between host_ack falling and the next host_rd/host_wr rising.
- Combinational routing, active in ISSUE and ACTIVE only, all zero otherwise:
  - cl_ack[grant]=host_ack.
  - cl_buff_wr[grant]=host_buff_wr.
  - Non-granted channels see 0 on both.
- host_buff_din=cl_buff_din[grant] in every state.
- host_lba is stable from the grant edge until the next grant. New cl_lba values are ignored while busy.
- Requests arriving while busy wait. No request is lost while its level is held.
- A host_ack outside ISSUE/ACTIVE is ignored and is not routed.

Test Plan:
1. Single read: cl_rd[1]=1, cl_lba[1]=32'h00000123; host_ack high 3 cycles later for 600 cycles.
   -> host_rd rises 1 cycle after the request with host_lba=0x123.
   -> cl_ack[1] mirrors host_ack; cl_ack[0,2,3]=0.
   -> DONE then IDLE; grant=1.
2. Round-robin fairness: cl_rd[0] and cl_rd[2] held high, each released on its ack.
   -> Grant order is 0, 2, 0, 2 (or 2, 0, ... depending on reset last=3, so first grant is 0).
   -> Never the same channel twice while the other waits.
3. Write buffer path: cl_wr[3]=1; host pulses host_buff_wr 512 times; cl_buff_din[3]=8'hA5, other channels 8'h00.
   -> host_buff_din=8'hA5 throughout.
   -> cl_buff_wr[3] receives exactly 512 pulses; other channels 0.
4. Abort: cl_rd[0]=1, dropped after 5 cycles with no host_ack.
   -> host_rd falls on the next edge; state IDLE; timeout_err=0.
   -> A later cl_rd[1] is granted normally.
5. Timeout with TIMEOUT_CYC=16: cl_wr[2] held, no ack.
   -> host_wr high for exactly 16 cycles, then low.
   -> timeout_err=1 and stays 1; the next request is granted to channel 3 or 0, not 2 first.
6. Reset mid-transfer: RESET_N low during ACTIVE.
   -> host_rd, host_wr, cl_ack and busy are 0 immediately (asynchronously).
   -> After release, state IDLE and grant=0.

Source files
------------

// File: rtl/sd_blk_arbiter.sv
// sd_blk_arbiter: merges up to four SD block-request clients onto one
// hps_io SD channel. Round-robin grant, latched LBA/operation, routed
// ack/buffer strobes, client abort and ack-timeout recovery.
module sd_blk_arbiter #(
  parameter int          NUM_CH      = 4,
  parameter logic [23:0] TIMEOUT_CYC = 24'd10000000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] cl_lba [4],
  input  logic [3:0]  cl_rd,
  input  logic [3:0]  cl_wr,
  output logic [3:0]  cl_ack,
  input  logic [7:0]  cl_buff_din [4],
  output logic [3:0]  cl_buff_wr,
  output logic [31:0] host_lba,
  output logic        host_rd,
  output logic        host_wr,
  input  logic        host_ack,
  input  logic        host_buff_wr,
  output logic [7:0]  host_buff_din,
  output logic        busy,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] lba_q, lba_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [23:0] timer_q, timer_d;
  logic        terr_q, terr_d;

  logic [3:0]  req;
  logic        route_en;
  logic        win_found;
  logic [1:0]  win_idx;

  assign route_en = (state_q == ISSUE) || (state_q == ACTIVE);

  // Per-channel request qualification and grant-gated routing of host strobes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_ch
    assign req[gi]        = (gi < NUM_CH) && (cl_rd[gi] || cl_wr[gi]);
    assign cl_ack[gi]     = route_en && (grant_q == 2'(gi)) && host_ack;
    assign cl_buff_wr[gi] = route_en && (grant_q == 2'(gi)) && host_buff_wr;
  end

  // Round-robin search starting just after the last served channel.
  always_comb begin
    logic [2:0] cand;
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = 3'd0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = {1'b0, last_q} + 3'(k);
      if (cand >= 3'(NUM_CH)) cand = cand - 3'(NUM_CH);
      if (!win_found && req[cand[1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[1:0];
      end
    end
  end

  // Next-state logic: grant, issue handshake, abort/timeout recovery.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    lba_d   = lba_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    timer_d = timer_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          lba_d   = cl_lba[win_idx];
          rd_d    = cl_rd[win_idx];
          wr_d    = cl_wr[win_idx] & ~cl_rd[win_idx];
          timer_d = 24'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = timer_q + 24'd1;
        if (host_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ACTIVE;
        end else if (!req[grant_q]) begin
          // Client withdrew before the host answered; its turn is not consumed.
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = IDLE;
        end else if ((TIMEOUT_CYC != 24'd0) && (timer_q == TIMEOUT_CYC - 24'd1)) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          terr_d  = 1'b1;
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (!host_ack) state_d = DONE;
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      grant_q <= 2'd0;
      last_q  <= 2'(NUM_CH - 1);
      lba_q   <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      timer_q <= 24'd0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      lba_q   <= lba_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      timer_q <= timer_d;
      terr_q  <= terr_d;
    end
  end

  assign host_lba      = lba_q;
  assign host_rd       = rd_q;
  assign host_wr       = wr_q;
  assign host_buff_din = cl_buff_din[grant_q];
  assign busy          = (state_q != IDLE);
  assign grant         = grant_q;
  assign timeout_err   = terr_q;

endmodule
